// File: rtl/jstk_spi_reader.sv
// jstk_spi_reader
// Periodically polls a PmodJSTK joystick over SPI mode 0. Each transaction
// is five bytes. Byte 0 carries the LED command and the rest are zeros. The
// five bytes received are the X/Y positions and the button state. New
// samples are published atomically with a one-cycle data_valid strobe.
// The registered paddle commands are decoded from the published Y value.
//
// Build option:
//   JSTK_DEADZONE_EN  - when defined, paddle_up/paddle_down use a deadzone of
//                       +/-DEADZONE around centre 512. When it is undefined,
//                       any deviation from 512 counts.
module jstk_spi_reader #(
    parameter int SCLK_HALF_DIV = 25,
    parameter int SS_SETUP      = 1000,
    parameter int BYTE_GAP      = 800,
    parameter int POLL_PERIOD   = 500000,
    parameter int DEADZONE      = 64
) (
    input  logic       board_clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [1:0] led_cmd,
    input  logic       miso,
    output logic       ss,
    output logic       sclk,
    output logic       mosi,
    output logic [9:0] x_pos,
    output logic [9:0] y_pos,
    output logic [2:0] buttons,
    output logic       data_valid,
    output logic       busy,
    output logic       paddle_up,
    output logic       paddle_down
);

    localparam int PW   = (POLL_PERIOD > 1) ? $clog2(POLL_PERIOD) : 1;
    localparam int HW   = $clog2(SCLK_HALF_DIV + 1);
    localparam int CMAX = (SS_SETUP > BYTE_GAP) ? SS_SETUP : BYTE_GAP;
    localparam int CW   = $clog2(CMAX + 1);

    localparam logic [PW-1:0] POLL_LAST  = PW'(POLL_PERIOD - 1);
    localparam logic [HW-1:0] HALF_LAST  = HW'(SCLK_HALF_DIV - 1);
    localparam logic [CW-1:0] SETUP_LAST = CW'(SS_SETUP - 1);
    localparam logic [CW-1:0] GAP_LAST   = CW'(BYTE_GAP - 1);
    localparam logic [9:0]    CENTRE     = 10'd512;

`ifdef JSTK_DEADZONE_EN
    localparam int DZ_EFF = DEADZONE;
`else
    // Without the deadzone option DEADZONE has no effect on decoding.
    localparam int DZ_EFF = 0 * DEADZONE;
`endif
    localparam int UP_LIMIT   = 512 + DZ_EFF;
    localparam int DOWN_LIMIT = 512 - DZ_EFF;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        GAP,
        DONE
    } state_t;

    state_t state, next_state;

    logic [PW-1:0] poll_cnt;
    logic [CW-1:0] phase_cnt;
    logic [HW-1:0] half_cnt;
    logic [2:0]    bit_cnt;
    logic [2:0]    byte_cnt;
    logic [7:0]    tx_shift;
    logic [7:0]    rx_shift;
    logic [7:0]    tx_byte;
    logic [1:0]    led_lat;
    logic [7:0]    x_lo, y_lo;
    logic [1:0]    x_hi, y_hi;
    logic [9:0]    x_new, y_new;
    logic          up_new, down_new;
    logic          poll_last, half_last, byte_end;
    logic          enter_setup, enter_shift, publish;

    assign poll_last = (poll_cnt == POLL_LAST);
    assign half_last = (half_cnt == HALF_LAST);
    // The last half-period of bit 0 ends with sclk high.
    assign byte_end  = sclk && half_last && (bit_cnt == 3'd7);
    assign tx_byte   = (byte_cnt == 3'd0) ? {6'b100000, led_lat} : 8'h00;

    // Assemble the published sample from the bytes already stored and the last byte.
    assign x_new    = {x_hi, x_lo};
    assign y_new    = {y_hi, y_lo};
    assign up_new   = int'(y_new) > UP_LIMIT;
    assign down_new = int'(y_new) < DOWN_LIMIT;

    assign busy = ~ss;

    // State register.
    always_ff @(posedge board_clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // register samples pre-edge values regardless of block ordering.
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    // Next-state decode plus the one-shot transition strobes.
    always_comb begin
        // NOTE: every output of this block gets a default first; a path that
        // left one unassigned would infer a latch.
        next_state  = state;
        enter_setup = 1'b0;
        enter_shift = 1'b0;
        publish     = 1'b0;
        case (state)
            IDLE: begin
                if (poll_last && enable) begin
                    next_state  = SETUP;
                    enter_setup = 1'b1;
                end
            end
            SETUP: begin
                if (phase_cnt == SETUP_LAST) begin
                    next_state  = SHIFT;
                    enter_shift = 1'b1;
                end
            end
            SHIFT: begin
                if (byte_end) begin
                    if (byte_cnt == 3'd4) begin
                        next_state = DONE;
                        publish    = 1'b1;
                    end else begin
                        next_state = GAP;
                    end
                end
            end
            GAP: begin
                if (phase_cnt == GAP_LAST) begin
                    next_state  = SHIFT;
                    enter_shift = 1'b1;
                end
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Free-running poll counter; a missed start simply waits for the next wrap.
    always_ff @(posedge board_clk or posedge reset) begin
        if (reset)          poll_cnt <= '0;
        else if (poll_last) poll_cnt <= '0;
        else                poll_cnt <= poll_cnt + 1'b1;
    end

    // Frame control: slave select, SETUP/GAP duration counter and LED latch.
    always_ff @(posedge board_clk or posedge reset) begin
        if (reset) begin
            ss        <= 1'b1;
            phase_cnt <= '0;
            led_lat   <= 2'b00;
        end else begin
            ss <= !(next_state inside {SETUP, SHIFT, GAP});
            if (next_state != state)
                phase_cnt <= '0;
            else if (state == SETUP || state == GAP)
                phase_cnt <= phase_cnt + 1'b1;
            if (enter_setup)
                led_lat <= led_cmd;
        end
    end

    // Bit engine: sclk generation, MSB-first mosi, miso capture on sclk rise.
    always_ff @(posedge board_clk or posedge reset) begin
        if (reset) begin
            sclk     <= 1'b0;
            mosi     <= 1'b0;
            half_cnt <= '0;
            bit_cnt  <= '0;
            byte_cnt <= '0;
            tx_shift <= '0;
            rx_shift <= '0;
            x_lo     <= '0;
            x_hi     <= '0;
            y_lo     <= '0;
            y_hi     <= '0;
        end else if (state != SHIFT) begin
            sclk     <= 1'b0;
            half_cnt <= '0;
            bit_cnt  <= '0;
            if (state == IDLE)
                byte_cnt <= '0;
            // mosi is presented while sclk is still low, ahead of the first rise.
            if (enter_shift) begin
                mosi     <= tx_byte[7];
                tx_shift <= {tx_byte[6:0], 1'b0};
            end
        end else if (!half_last) begin
            half_cnt <= half_cnt + 1'b1;
        end else begin
            half_cnt <= '0;
            if (!sclk) begin
                sclk     <= 1'b1;
                rx_shift <= {rx_shift[6:0], miso};
            end else begin
                sclk <= 1'b0;
                if (bit_cnt == 3'd7) begin
                    bit_cnt  <= '0;
                    mosi     <= 1'b0;
                    byte_cnt <= byte_cnt + 3'd1;
                    case (byte_cnt)
                        3'd0:    x_lo <= rx_shift;
                        3'd1:    x_hi <= rx_shift[1:0];
                        3'd2:    y_lo <= rx_shift;
                        3'd3:    y_hi <= rx_shift[1:0];
                        default: ;
                    endcase
                end else begin
                    bit_cnt  <= bit_cnt + 3'd1;
                    mosi     <= tx_shift[7];
                    tx_shift <= {tx_shift[6:0], 1'b0};
                end
            end
        end
    end

    // Publish: all visible results change together, only on entry to DONE.
    always_ff @(posedge board_clk or posedge reset) begin
        if (reset) begin
            x_pos       <= CENTRE;
            y_pos       <= CENTRE;
            buttons     <= 3'b000;
            data_valid  <= 1'b0;
            paddle_up   <= 1'b0;
            paddle_down <= 1'b0;
        end else begin
            data_valid <= publish;
            if (publish) begin
                x_pos       <= x_new;
                y_pos       <= y_new;
                buttons     <= rx_shift[2:0];
                paddle_up   <= up_new;
                paddle_down <= down_new;
            end
        end
    end

endmodule

// File: doc/jstk_spi_reader.md
JSTK_SPI_READER -- requirements
Module: jstk_spi_reader

Interface
REQ-001 The block SHALL have parameter SCLK_HALF_DIV, default 25, meaning board_clk cycles per SCLK half-period (1 MHz SCLK at 50 MHz).
REQ-002 The block SHALL have parameter SS_SETUP, default 1000, meaning board_clk cycles from ss falling to the first SCLK edge.
REQ-003 The block SHALL have parameter BYTE_GAP, default 800, meaning idle board_clk cycles between bytes with SCLK low.
REQ-004 The block SHALL have parameter POLL_PERIOD, default 500000, meaning board_clk cycles between transaction starts.
REQ-005 The block SHALL have parameter DEADZONE, default 64, meaning the Y deadzone half-width around centre 512.
REQ-006 The block SHALL have these ports, clock and reset first:
- board_clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  permits new transactions.
- led_cmd  in  2  LED bits sent in byte 0.
- miso  in  1  SPI data from PmodJSTK.
- ss  out  1  active-low slave select.
- sclk  out  1  SPI clock, mode 0.
- mosi  out  1  SPI data to PmodJSTK.
- x_pos  out  10  last X sample.
- y_pos  out  10  last Y sample.
- buttons  out  3  last button byte bits [2:0].
- data_valid  out  1  one-cycle strobe when new data is published.
- busy  out  1  high while ss is low.
- paddle_up  out  1  registered up command.
- paddle_down  out  1  registered down command.

Function
REQ-007 The FSM SHALL use the states IDLE, SETUP, SHIFT, GAP and DONE.
REQ-008 In IDLE, when the poll counter reaches POLL_PERIOD-1 and enable is 1, the block SHALL go to SETUP and drive ss low; otherwise it SHALL stay in IDLE.
REQ-009 The poll counter SHALL be free-running and wrap to 0 at POLL_PERIOD-1; a start missed because enable=0 SHALL wait for the next wrap.
REQ-010 SETUP SHALL last SS_SETUP cycles and then go to SHIFT.
REQ-011 SHIFT SHALL transfer 8 bits MSB-first: sclk rises after SCLK_HALF_DIV cycles low, and miso is sampled on that rising edge; mosi changes only while sclk is low.
REQ-012 After each byte the block SHALL go to GAP (BYTE_GAP cycles, sclk low) and then back to SHIFT; after byte 4 it SHALL go to DONE instead.
REQ-013 A transaction SHALL be 5 bytes. Byte 0 sent is {6'b100000, led_cmd}, with led_cmd latched on entry to SETUP; bytes 1-4 sent are 8'h00.
REQ-014 The received bytes SHALL be mapped as rx0 = X[7:0], rx1 = X[9:8] in bits [1:0], rx2 = Y[7:0], rx3 = Y[9:8], rx4 = buttons in bits [2:0].
REQ-015 In DONE (one cycle) the block SHALL drive ss high, update x_pos, y_pos and buttons atomically, pulse data_valid for exactly that cycle, and return to IDLE.
REQ-016 Outputs SHALL NOT change outside DONE; a partial transaction SHALL never be published.
REQ-017 When enable falls mid-transaction, the transaction SHALL complete normally.
REQ-018 busy SHALL equal ~ss; sclk SHALL be 0 whenever ss is 1.
REQ-019 Total transaction length SHALL be SS_SETUP + 5*16*SCLK_HALF_DIV + 4*BYTE_GAP + 1 cycles, which requires POLL_PERIOD to exceed this value.
REQ-020 paddle_up and paddle_down SHALL update in the DONE cycle, so they are valid from the same cycle as data_valid, and SHALL never both be 1.

Reset
REQ-021 While reset=1 the block SHALL force, asynchronously: ss=1, sclk=0, mosi=0, x_pos=512, y_pos=512, buttons=0, data_valid=0, busy=0, paddle_up=0, paddle_down=0, FSM=IDLE, and all counters=0.
REQ-022 Reset asserted mid-transaction SHALL abort it immediately and discard the partial data.

Configuration
REQ-023 The macro JSTK_DEADZONE_EN SHALL select how the paddle commands are decoded.
- Defined: paddle_up = (y_pos > 512+DEADZONE) and paddle_down = (y_pos < 512-DEADZONE).
- Undefined: DEADZONE is ignored, paddle_up = (y_pos > 512) and paddle_down = (y_pos < 512).

Verification
REQ-024 Model returns rx = 8'h34, 8'h02, 8'hC8, 8'h01, 8'h05 -> x_pos=564, y_pos=456, buttons=3'b101, one data_valid pulse, and byte 0 on mosi = 8'h83 for led_cmd=2'b11.
REQ-025 y_pos=600 with JSTK_DEADZONE_EN defined -> paddle_up=1, paddle_down=0; y_pos=540 -> both 0; y_pos=540 without the macro -> paddle_up=1.
REQ-026 Reset pulsed during byte 2 -> ss=1 within the same cycle, x_pos stays at 512, and no data_valid pulse.
REQ-027 enable=0 held for 3 poll periods -> ss stays high; enable dropped during SHIFT -> the transaction completes and data_valid pulses once.
REQ-028 Timing check with SCLK_HALF_DIV=2, SS_SETUP=4, BYTE_GAP=3 -> exactly 40 sclk rising edges, ss low for 4+160+12 cycles, and miso sampled only on rising edges.
